window_addr_sequencer: RTL and testbench

Parametrised read-address sequencer for vertical K-row windows over a line-organised frame in single-port-read SRAM. For every column it issues K reads, one per window row, spaced by the row stride. It then advances one column and repeats for a programmed column count. A tag pipeline marks each returning SRAM word with its row index and an end-of-column flag. The block sits between the frame SRAM read port and the gaussianFilter window buffer, and generalises the fixed 5-row, 256-stride schedule to any window height, stride, read latency and scan direction, adding start/done control and a stall input.

---
 rtl/window_seq_pkg.sv | 30 +++
 rtl/tag_delay_line.sv | 57 +++++
 rtl/window_addr_sequencer.sv | 167 ++++++++++++++++
 tb/tb_window_addr_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_seq_pkg.sv
// Purpose: shared types and constants for the K-row window address sequencer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package window_seq_pkg;

    localparam int ROW_W    = 4;   // width of a window row index (K_ROWS <= 16)
    localparam int MAX_ROWS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // One 32-bit row offset per possible window row; entries past k_rows are zero.
    typedef logic [MAX_ROWS-1:0][31:0] row_off_tab_t;

    // Builds row*stride for every window row at elaboration time so the
    // datapath only needs a table lookup and an add/subtract.
    function automatic row_off_tab_t row_off_table(input int unsigned stride,
                                                   input int unsigned k_rows);
        row_off_tab_t tab;
        tab = '0;
        for (int unsigned i = 0; i < k_rows && i < MAX_ROWS; i++) begin
            tab[i] = stride * i;
        end
        return tab;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Purpose: DEPTH-stage shift register aligning {valid, row, col_end} tags with SRAM read data.
// Latency: exactly DEPTH cycles from input to output.
// Backpressure: none; never stalls, since issued reads always return.
// Ports: clk/reset (sync, active-low clear); in_vld/in_row/in_end tag input;
//        out_vld/out_row/out_end delayed tag; inflight = a valid tag sits in a non-output stage.
module tag_delay_line
    import window_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [ROW_W-1:0] in_row,
    input  logic             in_end,
    output logic             out_vld,
    output logic [ROW_W-1:0] out_row,
    output logic             out_end,
    output logic             inflight
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][ROW_W-1:0] row_q;
    logic [DEPTH-1:0]            end_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            row_q <= '0;
            end_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            row_q[0] <= in_row;
            end_q[0] <= in_end;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                row_q[i] <= row_q[i-1];
                end_q[i] <= end_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_row = row_q[DEPTH-1];
    assign out_end = end_q[DEPTH-1];

    // The output stage is excluded: when only it holds the last tag, done
    // can be registered to land in the cycle right after that tag.
    generate
        if (DEPTH > 1) begin : g_multi
            assign inflight = |vld_q[DEPTH-2:0];
        end else begin : g_single
            assign inflight = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/window_addr_sequencer.sv
// Purpose: issues K_ROWS vertically strided SRAM reads per column over col_count columns, tagging returned data.
// Latency: first rd_en one cycle after start; q_* follow rd_en by RAM_LAT cycles; done one cycle after last q_valid.
// Backpressure: hold freezes issue in the cycle it is high; reads already issued still return.
// Ports: clk, reset (sync active-low); start/base_addr/col_count/dir program a scan; hold stalls issue;
//        rd_addr/rd_en drive the SRAM; q_valid/q_row/q_col_end tag SRAM data; busy/done/err report status.
module window_addr_sequencer
    import window_seq_pkg::*;
#(
    parameter int          ADDR_W     = 20,
    parameter int unsigned ROW_STRIDE = 256,
    parameter int          K_ROWS     = 5,
    parameter int          RAM_LAT    = 1,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  col_count,
    input  logic              dir,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              q_valid,
    output logic [ROW_W-1:0]  q_row,
    output logic              q_col_end,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam row_off_tab_t      ROW_OFF     = row_off_table(ROW_STRIDE, K_ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(K_ROWS - 1);
    // Smallest anchor that keeps a descending window inside the address space.
    localparam logic [ADDR_W-1:0] MIN_BASE_DN = ADDR_W'(ROW_OFF[K_ROWS-1]);

    seq_state_t        state, nxt_state;
    logic [ADDR_W-1:0] col_ptr, nxt_col_ptr;
    logic [CNT_W-1:0]  cols_left, nxt_cols_left;
    logic [ROW_W-1:0]  row, nxt_row;
    logic              dir_q, nxt_dir;
    logic [ADDR_W-1:0] nxt_rd_addr;
    logic              nxt_rd_en;
    logic [ROW_W-1:0]  rd_row, nxt_rd_row;
    logic              nxt_done, nxt_err;

    // The read about to be issued: from the inputs when starting, otherwise
    // from the registered scan position.
    logic [ADDR_W-1:0] iss_col, iss_addr, row_off;
    logic [CNT_W-1:0]  iss_left;
    logic [ROW_W-1:0]  iss_row;
    logic              iss_dir, row_wrap, iss_last, do_issue;
    logic              tag_inflight;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            col_ptr   <= '0;
            cols_left <= '0;
            row       <= '0;
            dir_q     <= 1'b0;
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            rd_row    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt_state;
            col_ptr   <= nxt_col_ptr;
            cols_left <= nxt_cols_left;
            row       <= nxt_row;
            dir_q     <= nxt_dir;
            rd_addr   <= nxt_rd_addr;
            rd_en     <= nxt_rd_en;
            rd_row    <= nxt_rd_row;
            done      <= nxt_done;
            err       <= nxt_err;
        end
    end

    always_comb begin
        iss_col  = (state == IDLE) ? base_addr : col_ptr;
        iss_left = (state == IDLE) ? col_count : cols_left;
        iss_row  = (state == IDLE) ? '0 : row;
        iss_dir  = (state == IDLE) ? dir : dir_q;
        row_off  = ADDR_W'(ROW_OFF[iss_row]);
        iss_addr = iss_dir ? (iss_col + row_off) : (iss_col - row_off);
        row_wrap = (iss_row == LAST_ROW);
        iss_last = row_wrap && (iss_left == CNT_W'(1));

        nxt_state     = state;
        nxt_col_ptr   = col_ptr;
        nxt_cols_left = cols_left;
        nxt_row       = row;
        nxt_dir       = dir_q;
        nxt_rd_addr   = rd_addr;
        nxt_rd_en     = 1'b0;
        nxt_rd_row    = rd_row;
        nxt_done      = 1'b0;
        nxt_err       = 1'b0;
        do_issue      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!dir && (base_addr < MIN_BASE_DN)) begin
                        nxt_err = 1'b1;
                    end else if (col_count == '0) begin
                        nxt_done = 1'b1;
                    end else begin
                        // K_ROWS >= 2, so the first read is never the last.
                        do_issue  = 1'b1;
                        nxt_dir   = dir;
                        nxt_state = RUN;
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    do_issue = 1'b1;
                    if (iss_last) begin
                        nxt_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rd_en && !tag_inflight) begin
                    nxt_done  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (do_issue) begin
            nxt_rd_en   = 1'b1;
            nxt_rd_addr = iss_addr;
            nxt_rd_row  = iss_row;
            if (row_wrap) begin
                nxt_row       = '0;
                nxt_col_ptr   = iss_col + ADDR_W'(1);
                nxt_cols_left = iss_left - CNT_W'(1);
            end else begin
                nxt_row       = iss_row + ROW_W'(1);
                nxt_col_ptr   = iss_col;
                nxt_cols_left = iss_left;
            end
        end
    end

    assign busy = (state != IDLE);

    tag_delay_line #(
        .DEPTH (RAM_LAT)
    ) u_tags (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (rd_en),
        .in_row   (rd_row),
        .in_end   (rd_en && (rd_row == LAST_ROW)),
        .out_vld  (q_valid),
        .out_row  (q_row),
        .out_end  (q_col_end),
        .inflight (tag_inflight)
    );

endmodule

// File: tb/tb_window_addr_sequencer.sv
module tb_window_addr_sequencer;

    localparam int ADDR_W = 20;
    localparam int CNT_W  = 16;
    localparam int K      = 5;
    localparam int STRIDE = 256;
    localparam int LAT    = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  col_count = '0;
    logic              dir = 1'b0;
    logic              hold = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              q_valid;
    logic [3:0]        q_row;
    logic              q_col_end;
    logic              busy;
    logic              done;
    logic              err;

    window_addr_sequencer #(
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (STRIDE),
        .K_ROWS     (K),
        .RAM_LAT    (LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .col_count (col_count),
        .dir       (dir),
        .hold      (hold),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .q_valid   (q_valid),
        .q_row     (q_row),
        .q_col_end (q_col_end),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [ADDR_W-1:0] a; } rd_t;
    typedef struct { int c; logic [3:0] r; logic e; } qt_t;

    rd_t rdq[$];
    qt_t qq[$];
    int  doneq[$];
    int  errq[$];
    int  busy_lo = 0;
    int  busy_hi = 0;
    int  zero_c  = -1;
    bit  mon_en  = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit hold_at(input int x, input int t, input logic [63:0] m);
        int o;
        o = x - t;
        return (o >= 0 && o < 64) ? m[o] : 1'b0;
    endfunction

    // Monitor: every cycle, compares DUT outputs against whatever the
    // scoreboard expects for this cycle and pops what it consumed.
    bit e_rd, e_q, e_dn, e_er;
    always @(negedge clk) begin
        if (mon_en) begin
            e_rd = (rdq.size() > 0) && (rdq[0].c == cyc);
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            if (e_rd) begin
                if (rd_en) chk("rd_addr", 32'(rd_addr), 32'(rdq[0].a));
                void'(rdq.pop_front());
            end
            e_q = (qq.size() > 0) && (qq[0].c == cyc);
            chk("q_valid", 32'(q_valid), 32'(e_q));
            if (e_q) begin
                if (q_valid) begin
                    chk("q_row", 32'(q_row), 32'(qq[0].r));
                    chk("q_col_end", 32'(q_col_end), 32'(qq[0].e));
                end
                void'(qq.pop_front());
            end
            e_dn = (doneq.size() > 0) && (doneq[0] == cyc);
            chk("done", 32'(done), 32'(e_dn));
            if (e_dn) void'(doneq.pop_front());
            e_er = (errq.size() > 0) && (errq[0] == cyc);
            chk("err", 32'(err), 32'(e_er));
            if (e_er) void'(errq.pop_front());
            chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc < busy_hi));
            if (cyc == zero_c) begin
                chk("rst_rd_addr", 32'(rd_addr), 32'd0);
                chk("rst_q_row", 32'(q_row), 32'd0);
                chk("rst_q_col_end", 32'(q_col_end), 32'd0);
            end
        end
    end

    // Reference model: read n of a scan sits at column n/K, row n%K, and is
    // issued in the first cycle after read n-1 whose preceding cycle had hold low.
    task automatic run_job(input logic [ADDR_W-1:0] b, input int cnt, input bit d,
                           input logic [63:0] hm, input int roff, input bit inj);
        int t, r, c, dn, endc, row;
        logic [ADDR_W-1:0] a, col;
        @(posedge clk); #1;
        t = cyc;
        r = (roff > 0) ? t + roff : 32'h3fff_ffff;
        start = 1'b1; base_addr = b; col_count = CNT_W'(cnt); dir = d; hold = hm[0];
        busy_lo = 0; busy_hi = 0; endc = t + 1;
        if (!d && int'(b) < (K - 1) * STRIDE) begin
            if (t + 1 <= r) errq.push_back(t + 1);
        end else if (cnt == 0) begin
            if (t + 1 <= r) doneq.push_back(t + 1);
        end else begin
            c = t + 1;
            for (int n = 0; n < K * cnt; n++) begin
                if (n > 0) begin
                    c++;
                    while (hold_at(c - 1, t, hm)) c++;
                end
                col = b + ADDR_W'(n / K);
                row = n % K;
                a = d ? col + ADDR_W'(row * STRIDE) : col - ADDR_W'(row * STRIDE);
                if (c <= r) rdq.push_back('{c, a});
                if (c + LAT <= r) qq.push_back('{c + LAT, 4'(row), row == K - 1});
            end
            dn = c + LAT + 1;
            if (dn <= r) doneq.push_back(dn);
            busy_lo = t + 1;
            busy_hi = (dn < r + 1) ? dn : r + 1;
            endc = dn;
        end
        if (roff > 0) begin
            zero_c = r + 1;
            if (r + 1 > endc) endc = r + 1;
        end
        while (cyc < endc + 2) begin
            @(posedge clk); #1;
            start = inj && (cyc == t + 2) && (busy_hi > t + 2);
            if (start) begin
                base_addr = ADDR_W'($urandom);
                dir = 1'($urandom_range(0, 1));
                col_count = CNT_W'(3);
            end
            hold  = hold_at(cyc, t, hm);
            reset = !(cyc == r);
        end
        start = 1'b0; hold = 1'b0; reset = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] b;
        bit d, inj;
        int cnt, ro;
        logic [63:0] hm;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        zero_c = cyc;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;

        run_job(20'd1024, 2, 1'b0, 64'h0, 0, 1'b0);
        run_job(20'd1024, 2, 1'b0, 64'h38, 0, 1'b0);
        run_job(20'd1000, 2, 1'b0, 64'h0, 0, 1'b0);
        run_job(20'd0, 1, 1'b1, 64'h0, 0, 1'b0);
        run_job(20'd1024, 0, 1'b0, 64'h0, 0, 1'b0);
        run_job(20'd1024, 3, 1'b0, 64'h0, 4, 1'b0);
        run_job(20'd2000, 1, 1'b1, 64'h0, 0, 1'b0);
        run_job(20'hFFFFF, 2, 1'b0, 64'h0, 0, 1'b0);
        run_job(20'hFFFFE, 2, 1'b1, 64'h0, 0, 1'b0);
        run_job(20'd1024, 1, 1'b0, 64'h0, 0, 1'b1);
        run_job(20'd4096, 2, 1'b0, 64'h8000_0000_0000_0600, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            d   = 1'($urandom_range(0, 1));
            b   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 1500)) : ADDR_W'($urandom);
            cnt = int'($urandom_range(0, 4));
            hm  = '0;
            for (int i = 1; i < 64; i++) hm[i] = ($urandom_range(0, 3) == 0);
            ro  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 14)) : 0;
            inj = 1'($urandom_range(0, 1));
            run_job(b, cnt, d, hm, ro, inj);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        chk("qq_drained", 32'(qq.size()), 32'd0);
        chk("doneq_drained", 32'(doneq.size()), 32'd0);
        chk("errq_drained", 32'(errq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
